// File: rtl/wshb_arbiter.sv
// rtl/wshb_arbiter.sv - two-master to one-slave Wishbone arbiter
//
// Purpose:
//   Grants the SDRAM controller slave port to one of two Wishbone masters
//   for the full duration of that master's cyc. Master 0 is the framebuffer
//   writer, master 1 the display read-back master. Ties are broken
//   round-robin using the most recently granted master.
//
// Configuration:
//   WSHB_ARB_FIXED_PRIO_EN - when defined, master 1 wins every tie and the
//   round-robin history is ignored. Undefined: round-robin.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m0_* / m1_*         master request side (cyc, stb, we, adr, dat_ms,
//                       sel, cti, bte) and per-master ack
//   s_*                 slave request side, muxed from the granted master
//   s_dat_sm, s_ack     slave read data and acknowledge
//   m_dat_sm            slave read data broadcast to both masters
module wshb_arbiter #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic               m0_ack,

  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic               m1_ack,

  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_ms,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  input  logic [DAT_W-1:0]   s_dat_sm,
  input  logic               s_ack,

  output logic [DAT_W-1:0]   m_dat_sm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;       // most recently granted master
  logic   tie_to_m1;  // who wins when both cyc rise together in IDLE

`ifdef WSHB_ARB_FIXED_PRIO_EN
  assign tie_to_m1 = 1'b1;
`else
  // Round-robin: the master that was not served last wins the tie.
  assign tie_to_m1 = ~last;
`endif

  // Grant state. A grant is held for as long as the owner keeps cyc high;
  // when it drops, a waiting master takes over on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            if (tie_to_m1) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= GNT0;
              last  <= 1'b0;
            end
          end else if (m0_cyc) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (m1_cyc) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_cyc) begin
            if (m1_cyc) begin
              state <= GNT1;
              last  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            if (m0_cyc) begin
              state <= GNT0;
              last  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational routing. s_cyc follows the owner's cyc directly, so an
  // aborted cycle releases the slave in the same clock. Acks are gated by
  // the owner's cyc so a late slave ack after an abort is swallowed.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack & m0_cyc;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack & m1_cyc;
      end
      default: ;
    endcase
  end

  assign m_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb/tb_wshb_arbiter.sv - self-checking bench for wshb_arbiter
module tb_wshb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [15:0] dat [2];
  logic [1:0]  sel [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2];

  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [15:0] s_dat_ms;
  logic [1:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [15:0] s_dat_sm;
  logic        s_ack;
  logic [15:0] m_dat_sm;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the slave (-1 none) and who was served last.
  int owner;
  int last_m;

  always #5 clk = ~clk;

  wshb_arbiter #(.ADR_W(32), .DAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_adr(adr[0]),
    .m0_dat_ms(dat[0]), .m0_sel(sel[0]), .m0_cti(cti[0]), .m0_bte(bte[0]),
    .m0_ack(m0_ack),
    .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_adr(adr[1]),
    .m1_dat_ms(dat[1]), .m1_sel(sel[1]), .m1_cti(cti[1]), .m1_bte(bte[1]),
    .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .m_dat_sm(m_dat_sm)
  );

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int tie_winner();
`ifdef WSHB_ARB_FIXED_PRIO_EN
    return 1;
`else
    return 1 - last_m;
`endif
  endfunction

  function automatic void model_reset();
    owner  = -1;
    last_m = 1;
  endfunction

  function automatic void model_edge();
    int other;
    if (owner < 0) begin
      if (cyc[0] && cyc[1]) owner = tie_winner();
      else if (cyc[0])      owner = 0;
      else if (cyc[1])      owner = 1;
      if (owner >= 0) last_m = owner;
    end else if (!cyc[owner]) begin
      other = 1 - owner;
      if (cyc[other]) begin
        owner  = other;
        last_m = owner;
      end else begin
        owner = -1;
      end
    end
  endfunction

  task automatic check_model(string name);
    logic [57:0] ab, eb;
    logic        e0, e1;
    ab = {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte};
    if (owner < 0) eb = '0;
    else eb = {cyc[owner], stb[owner], we[owner], adr[owner], dat[owner],
               sel[owner], cti[owner], bte[owner]};
    e0 = (owner == 0) && cyc[0] && s_ack;
    e1 = (owner == 1) && cyc[1] && s_ack;
    check(name, 128'({ab, m0_ack, m1_ack, m_dat_sm}), 128'({eb, e0, e1, s_dat_sm}));
  endtask

  // Advance one clock: keep the model in step, then leave 1 ns of margin.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
  endtask

  function automatic logic [1:0] who(logic [31:0] a);
    case (a)
      32'h100: return 2'd1;
      32'h200: return 2'd2;
      32'h000: return 2'd0;
      default: return 2'd3;
    endcase
  endfunction

  typedef struct {
    logic       c0, c1, ack;
    logic       exp_cyc;
    logic [1:0] exp_gnt;
    logic       exp_a0, exp_a1;
  } vec_t;

  function automatic vec_t mk(logic c0, logic c1, logic ack, logic ec,
                              logic [1:0] eg, logic a0, logic a1);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.exp_cyc = ec; v.exp_gnt = eg; v.exp_a0 = a0; v.exp_a1 = a1;
    return v;
  endfunction

  task automatic set_fixed_fields();
    we[0] = 1'b1; adr[0] = 32'h100; dat[0] = 16'h1111; sel[0] = 2'b11; cti[0] = 3'd0; bte[0] = 2'd0;
    we[1] = 1'b0; adr[1] = 32'h200; dat[1] = 16'h2222; sel[1] = 2'b01; cti[1] = 3'd2; bte[1] = 2'd1;
  endtask

  task automatic clear_req();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0;
      stb[i] = 1'b0;
    end
    s_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [17];
    int   p0, p1;

    rst_n    = 1'b0;
    s_dat_sm = 16'h0;
    set_fixed_fields();
    clear_req();
    model_reset();

    // Reset hold: toggling inputs never reach the slave or acks.
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        cyc[i] = c[0] ^ i[0];
        stb[i] = 1'b1;
      end
      s_ack = 1'b1;
      #1;
      check("reset_hold", 128'({s_cyc, s_stb, m0_ack, m1_ack}), 128'(4'b0));
    end
    clear_req();
    tick();
    rst_n = 1'b1;

`ifndef WSHB_ARB_FIXED_PRIO_EN
    // Cycle-by-cycle vectors from reset: stray ack, tie, handovers, round-robin.
    tbl[0]  = mk(0,0,0, 0,2'd0,0,0);
    tbl[1]  = mk(1,1,1, 0,2'd0,0,0);
    tbl[2]  = mk(1,1,0, 1,2'd1,0,0);
    tbl[3]  = mk(1,1,1, 1,2'd1,1,0);
    tbl[4]  = mk(0,1,1, 0,2'd1,0,0);
    tbl[5]  = mk(1,1,1, 1,2'd2,0,1);
    tbl[6]  = mk(1,0,0, 0,2'd2,0,0);
    tbl[7]  = mk(1,1,0, 1,2'd1,0,0);
    tbl[8]  = mk(0,0,0, 0,2'd1,0,0);
    tbl[9]  = mk(1,1,0, 0,2'd0,0,0);
    tbl[10] = mk(1,1,0, 1,2'd2,0,0);
    tbl[11] = mk(1,0,0, 0,2'd2,0,0);
    tbl[12] = mk(0,0,0, 0,2'd1,0,0);
    tbl[13] = mk(0,1,0, 0,2'd0,0,0);
    tbl[14] = mk(0,0,0, 0,2'd2,0,0);
    tbl[15] = mk(1,1,0, 0,2'd0,0,0);
    tbl[16] = mk(1,0,0, 1,2'd1,0,0);
    for (int i = 0; i < 17; i++) begin
      tick();
      cyc[0] = tbl[i].c0; stb[0] = tbl[i].c0;
      cyc[1] = tbl[i].c1; stb[1] = tbl[i].c1;
      s_ack  = tbl[i].ack;
      #1;
      check($sformatf("vec%0d", i),
            128'({s_cyc, s_stb, who(s_adr), m0_ack, m1_ack}),
            128'({tbl[i].exp_cyc, tbl[i].exp_cyc, tbl[i].exp_gnt, tbl[i].exp_a0, tbl[i].exp_a1}));
    end
`endif
    clear_req();
    tick();
    tick();

    // Single master write with the slave acking two cycles after s_stb.
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h100; dat[0] = 16'hFFFF;
    #1;
    check("lat_req_cycle", 128'(s_cyc), 128'(1'b0));
    p0 = 0; p1 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 3) begin
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
      end
      s_ack = (c == 2);
      #1;
      if (c == 0)
        check("single_granted", 128'({s_cyc, s_stb, s_we, s_adr, s_dat_ms}),
              128'({1'b1, 1'b1, 1'b1, 32'h100, 16'hFFFF}));
      p0 += int'(m0_ack);
      p1 += int'(m1_ack);
    end
    check("single_m0_ack_pulses", 128'(p0), 128'(1));
    check("single_m1_ack_pulses", 128'(p1), 128'(0));
    set_fixed_fields();
    clear_req();
    tick();

    // Long hold: m1 keeps cyc for 20 acked beats while m0 waits.
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; s_ack = 1'b1;
    for (int b = 0; b < 20; b++) begin
      if (b > 0) tick();
      #1;
      check("hold_beat", 128'({s_cyc, s_adr, m0_ack, m1_ack}),
            128'({1'b1, 32'h200, 1'b0, 1'b1}));
    end
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
    #1;
    check("hold_drop", 128'({s_cyc, m0_ack, m1_ack}), 128'(3'b0));
    tick();
    #1;
    check("hold_handover", 128'({s_cyc, s_stb, s_adr}), 128'({1'b1, 1'b1, 32'h100}));

    // Abort without ack, then stray acks are discarded.
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0; s_ack = 1'b1;
    #1;
    check("abort_ack", 128'({s_cyc, m0_ack, m1_ack}), 128'(3'b0));
    tick();
    #1;
    check("stray_ack_idle", 128'({s_cyc, m0_ack, m1_ack}), 128'(3'b0));
    clear_req();

    // Mid-transfer reset during a GNT1 read.
    tick();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    #1;
    check("midrst_gnt1", 128'({s_cyc, s_adr}), 128'({1'b1, 32'h200}));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_async", 128'({s_cyc, s_stb, m0_ack, m1_ack}), 128'(4'b0));
    tick();
    rst_n  = 1'b1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    #1;
    check("midrst_req_cycle", 128'(s_cyc), 128'(1'b0));
    tick();
    #1;
    check("midrst_regrant", 128'({s_cyc, s_adr}), 128'({1'b1, 32'h100}));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 5) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] & ($urandom_range(0, 3) != 0);
        we[i]  = 1'($urandom);
        adr[i] = $urandom;
        dat[i] = 16'($urandom);
        sel[i] = 2'($urandom);
        cti[i] = 3'($urandom);
        bte[i] = 2'($urandom);
      end
      s_ack    = 1'($urandom);
      s_dat_sm = 16'($urandom);
      #1;
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
